// File: rtl/vga_overlay_pkg.sv
// rtl/vga_overlay_pkg.sv - segment table, colour constants and segment indices for the digit overlay
package vga_overlay_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COL_BLACK = 24'h000000;
  localparam rgb_t COL_FG    = 24'h00FF00;
  localparam rgb_t COL_ALERT = 24'hFF0000;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // bit order {g,f,e,d,c,b,a}; codes 10..15 light nothing
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

endpackage

// File: rtl/vga_digit_overlay_if.sv
// rtl/vga_digit_overlay_if.sv - pixel position, syncs and colour bundle around the overlay
interface vga_digit_overlay_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       h_sync_in;
  logic       v_sync_in;
  logic       blank_n_in;
  logic       h_sync_out;
  logic       v_sync_out;
  logic       blank_n_out;
  logic [7:0] vga_red;
  logic [7:0] vga_green;
  logic [7:0] vga_blue;

  modport master (
    output x, y, h_sync_in, v_sync_in, blank_n_in,
    input  h_sync_out, v_sync_out, blank_n_out, vga_red, vga_green, vga_blue
  );

  modport slave (
    input  x, y, h_sync_in, v_sync_in, blank_n_in,
    output h_sync_out, v_sync_out, blank_n_out, vga_red, vga_green, vga_blue
  );
endinterface

// File: rtl/vga_seg_glyph.sv
// rtl/vga_seg_glyph.sv - combinational seven-segment hit test for one W x H digit cell
module vga_seg_glyph
  import vga_overlay_pkg::*;
#(
  parameter int W   = 40,
  parameter int H   = 80,
  parameter int T   = 6,
  parameter int DXW = 7,
  parameter int DYW = 10
) (
  input  logic [DXW-1:0] dx,
  input  logic [DYW-1:0] dy,
  input  logic [3:0]     digit,
  output logic           lit
);

  int         w_x;
  int         w_y;
  logic [6:0] w_seg;

  always_comb begin
    w_x = int'(dx);
    w_y = int'(dy);
    w_seg = '0;
    w_seg[SEG_A] = (w_y < T);
    w_seg[SEG_D] = (w_y >= H - T);
    w_seg[SEG_G] = (w_y >= H/2 - T/2) && (w_y < H/2 + T/2);
    w_seg[SEG_F] = (w_x < T) && (w_y < H/2);
    w_seg[SEG_B] = (w_x >= W - T) && (w_y < H/2);
    w_seg[SEG_E] = (w_x < T) && (w_y >= H/2);
    w_seg[SEG_C] = (w_x >= W - T) && (w_y >= H/2);
    lit = |(w_seg & SEG_TABLE[digit]);
  end

endmodule

// File: rtl/vga_digit_overlay.sv
// rtl/vga_digit_overlay.sv - two-stage seven-segment digit overlay with per-frame digit latch and alert blink
// VGA_DIGIT_LZB_EN enables leading-zero blanking of the latched digits.
module vga_digit_overlay
  import vga_overlay_pkg::*;
#(
  parameter int         NUM_DIGITS   = 4,
  parameter int         ORIGIN_X     = 365,
  parameter int         ORIGIN_Y     = 160,
  parameter int         DIGIT_W      = 40,
  parameter int         DIGIT_H      = 80,
  parameter int         GAP          = 30,
  parameter int         SEG_T        = 6,
  parameter logic [7:0] COLON_MASK   = 8'b0000_0010,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic                    clk_25mhz,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    time_out,
  vga_digit_overlay_if.slave      vif
);

  localparam int PITCH    = DIGIT_W + GAP;
  localparam int DXW      = $clog2(PITCH);
  localparam int IW       = $clog2(NUM_DIGITS + 1);
  localparam int FCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int COLON_X0 = DIGIT_W + GAP/2 - SEG_T/2;
  localparam int COLON_Y0 = DIGIT_H/4 - SEG_T/2;
  localparam int COLON_Y1 = 3*DIGIT_H/4 - SEG_T/2;

  logic [3:0]            r_shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_lzb;
  logic [FCW-1:0]        r_frame_cnt;
  logic                  r_phase;

  logic                  w_frame_start;
  logic [3:0]            w_load [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_load_blank;

  assign w_frame_start = (vif.x == 10'd0) && (vif.y == 10'd0);

  always_comb begin
`ifdef VGA_DIGIT_LZB_EN
    logic w_lead;
    w_lead = 1'b1;
`endif
    w_load_blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load[i] = digits_in[4*(NUM_DIGITS-1-i) +: 4];
    end
`ifdef VGA_DIGIT_LZB_EN
    // the rightmost cell always shows, so a zero value still renders "0"
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      if (w_lead && (w_load[i] == 4'd0)) begin
        w_load[i]       = 4'hF;
        w_load_blank[i] = 1'b1;
      end else begin
        w_lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= 4'hF;
      r_lzb       <= '0;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_frame_start) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= w_load[i];
      r_lzb <= w_load_blank;
      if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + FCW'(1);
      end
    end
  end

  // stage 1: cell tracker counts along the line instead of dividing x
  logic           r1_active;
  logic [IW-1:0]  r1_idx;
  logic [DXW-1:0] r1_dx;
  logic           r1_in_rows;
  logic [9:0]     r1_dy;
  logic           r1_hs;
  logic           r1_vs;
  logic           r1_bn;

  logic           w_active_nxt;
  logic [IW-1:0]  w_idx_nxt;
  logic [DXW-1:0] w_dx_nxt;
  logic           w_in_rows;

  always_comb begin
    w_active_nxt = r1_active;
    w_idx_nxt    = r1_idx;
    w_dx_nxt     = r1_dx;
    if (vif.x == 10'(ORIGIN_X)) begin
      w_active_nxt = 1'b1;
      w_idx_nxt    = '0;
      w_dx_nxt     = '0;
    end else if (r1_active) begin
      if (r1_dx == DXW'(PITCH - 1)) begin
        w_dx_nxt  = '0;
        w_idx_nxt = r1_idx + IW'(1);
        if (r1_idx == IW'(NUM_DIGITS - 1)) w_active_nxt = 1'b0;
      end else begin
        w_dx_nxt = r1_dx + DXW'(1);
      end
    end
  end

  assign w_in_rows = (vif.y >= 10'(ORIGIN_Y)) && ((vif.y - 10'(ORIGIN_Y)) < 10'(DIGIT_H));

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r1_active  <= 1'b0;
      r1_idx     <= '0;
      r1_dx      <= '0;
      r1_in_rows <= 1'b0;
      r1_dy      <= '0;
      r1_hs      <= 1'b1;
      r1_vs      <= 1'b1;
      r1_bn      <= 1'b0;
    end else begin
      r1_active  <= w_active_nxt;
      r1_idx     <= w_idx_nxt;
      r1_dx      <= w_dx_nxt;
      r1_in_rows <= w_in_rows;
      r1_dy      <= vif.y - 10'(ORIGIN_Y);
      r1_hs      <= vif.h_sync_in;
      r1_vs      <= vif.v_sync_in;
      r1_bn      <= vif.blank_n_in;
    end
  end

  // stage 2: segment / colon hit test and colour select
  logic [3:0] w_digit;
  logic       w_colon_en;
  logic       w_glyph_lit;
  logic       w_colon_hit;
  logic       w_lit;
  rgb_t       r_rgb;
  logic       r2_hs;
  logic       r2_vs;
  logic       r2_bn;

  always_comb begin
    w_digit    = 4'hF;
    w_colon_en = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r1_idx == IW'(i)) begin
        w_digit    = r_shadow[i];
        w_colon_en = COLON_MASK[i] && (i < NUM_DIGITS - 1) && !r_lzb[i];
      end
    end
  end

  vga_seg_glyph #(
    .W   (DIGIT_W),
    .H   (DIGIT_H),
    .T   (SEG_T),
    .DXW (DXW),
    .DYW (10)
  ) u_glyph (
    .dx    (r1_dx),
    .dy    (r1_dy),
    .digit (w_digit),
    .lit   (w_glyph_lit)
  );

  assign w_colon_hit = (r1_dx >= DXW'(COLON_X0)) && (r1_dx < DXW'(COLON_X0 + SEG_T)) &&
                       (((r1_dy >= 10'(COLON_Y0)) && (r1_dy < 10'(COLON_Y0 + SEG_T))) ||
                        ((r1_dy >= 10'(COLON_Y1)) && (r1_dy < 10'(COLON_Y1 + SEG_T))));

  assign w_lit = r1_active && r1_in_rows &&
                 (((r1_dx < DXW'(DIGIT_W)) && w_glyph_lit) || (w_colon_en && w_colon_hit));

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_rgb <= COL_BLACK;
      r2_hs <= 1'b1;
      r2_vs <= 1'b1;
      r2_bn <= 1'b0;
    end else begin
      if (r1_bn && w_lit) r_rgb <= (time_out && r_phase) ? COL_ALERT : COL_FG;
      else                r_rgb <= COL_BLACK;
      r2_hs <= r1_hs;
      r2_vs <= r1_vs;
      r2_bn <= r1_bn;
    end
  end

  assign vif.vga_red     = r_rgb[23:16];
  assign vif.vga_green   = r_rgb[15:8];
  assign vif.vga_blue    = r_rgb[7:0];
  assign vif.h_sync_out  = r2_hs;
  assign vif.v_sync_out  = r2_vs;
  assign vif.blank_n_out = r2_bn;

endmodule

// File: tb/tb_vga_digit_overlay.sv
// tb/tb_vga_digit_overlay.sv - scoreboard bench for vga_digit_overlay with directed pixel probes
module tb_vga_digit_overlay;

  localparam int OX    = 365;
  localparam int OY    = 160;
  localparam int PITCH = 70;
  localparam int BF    = 2;
  localparam logic [23:0] G = 24'h00FF00;
  localparam logic [23:0] R = 24'hFF0000;
  localparam logic [23:0] K = 24'h000000;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bn;
    int          px;
    int          py;
  } exp_t;

  typedef struct {
    int          px;
    logic [23:0] rgb;
  } probe_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h1238;
  logic        time_out = 1'b0;

  vga_digit_overlay_if vif();

  vga_digit_overlay #(.BLINK_FRAMES(BF)) dut (
    .clk_25mhz (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .time_out  (time_out),
    .vif       (vif)
  );

  always #20 clk = ~clk;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   exp_q[$];
  probe_t probes[$];
  exp_t   mon_e;
  int     bn_off_x = -1;
  int     drop_x = -1;
  int     m_cnt = 0;
  logic   m_phase = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (mon_e.due != cyc) begin
        n_bad++;
        $display("FAIL late px(%0d,%0d): due %0d seen %0d", mon_e.px, mon_e.py, mon_e.due, cyc);
      end else if ({vif.vga_red, vif.vga_green, vif.vga_blue, vif.h_sync_out, vif.v_sync_out, vif.blank_n_out}
                   !== {mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.bn}) begin
        n_bad++;
        $display("FAIL px(%0d,%0d): got rgb=%h hs=%b vs=%b bn=%b, want rgb=%h hs=%b vs=%b bn=%b",
                 mon_e.px, mon_e.py, {vif.vga_red, vif.vga_green, vif.vga_blue},
                 vif.h_sync_out, vif.v_sync_out, vif.blank_n_out,
                 mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.bn);
      end
    end
  end

  task automatic probe(input int px, input logic [23:0] rgb);
    probe_t p;
    p.px = px;
    p.rgb = rgb;
    probes.push_back(p);
  endtask

  task automatic sweep(input int yy);
    exp_t e;
    for (int xx = OX - 4; xx <= OX + 4*PITCH + 2; xx++) begin
      @(negedge clk);
      vif.x          = xx[9:0];
      vif.y          = yy[9:0];
      vif.h_sync_in  = xx[0];
      vif.v_sync_in  = yy[0];
      vif.blank_n_in = (xx != bn_off_x);
      if (xx == drop_x) time_out = 1'b0;
      foreach (probes[i]) begin
        if (probes[i].px == xx) begin
          e.due = cyc + 2;
          e.rgb = probes[i].rgb;
          e.hs  = xx[0];
          e.vs  = yy[0];
          e.bn  = (xx != bn_off_x);
          e.px  = xx;
          e.py  = yy;
          exp_q.push_back(e);
        end
      end
    end
    probes.delete();
  endtask

  task automatic frame_start(input logic [15:0] d);
    @(negedge clk);
    digits_in      = d;
    vif.x          = 10'd0;
    vif.y          = 10'd0;
    vif.h_sync_in  = 1'b1;
    vif.v_sync_in  = 1'b0;
    vif.blank_n_in = 1'b0;
    if (m_cnt == BF - 1) begin
      m_cnt   = 0;
      m_phase = ~m_phase;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    exp_t e;
    vif.x = 10'd400; vif.y = 10'd170;
    vif.h_sync_in = 1'b0; vif.v_sync_in = 1'b0; vif.blank_n_in = 1'b1;

    // reset held mid-line: outputs idle regardless of inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      e.due = cyc + 1; e.rgb = K; e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0; e.px = 400; e.py = 170;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rst = 1'b0;

    // before any frame start the shadow is blank
    probe(OX + 3*PITCH, K); probe(OX + 3*PITCH + 34, K);
    sweep(170);

    // digits 1,2,3,8
    frame_start(16'h1238);
    probe(OX + 3*PITCH + 2, G);
    sweep(OY + 2);
    probe(OX + 3*PITCH - 1, K); probe(OX + 3*PITCH, G); probe(OX + 3*PITCH + 5, G);
    probe(OX + 3*PITCH + 6, K); probe(OX + 3*PITCH + 33, K); probe(OX + 3*PITCH + 34, G);
    probe(OX + 2, K); probe(OX + 35, G); probe(OX + PITCH + 2, K); probe(OX + PITCH + 36, G);
    probe(OX - 1, K);
    sweep(170);
    probe(OX + 3*PITCH + 2, G); probe(OX + 2, K); probe(OX + PITCH + 2, G);
    sweep(OY + 40);
    probe(OX + PITCH + 51, K); probe(OX + PITCH + 52, G); probe(OX + PITCH + 54, G);
    probe(OX + PITCH + 57, G); probe(OX + PITCH + 58, K); probe(OX + 55, K);
    sweep(OY + 20);
    bn_off_x = OX + 3*PITCH + 2;
    probe(OX + 3*PITCH + 2, K); probe(OX + 3*PITCH + 3, G);
    sweep(OY + 2);
    bn_off_x = -1;

    // no tearing: change at y=200 only shows next frame
    frame_start(16'h1234);
    probe(OX + 15, K); probe(OX + 3*PITCH + 15, K);
    sweep(OY + 2);
    sweep(200);
    digits_in = 16'h5678;
    probe(OX + 15, K); probe(OX + 3*PITCH + 15, K);
    sweep(OY + 76);
    frame_start(16'h5678);
    probe(OX + 15, G); probe(OX + 3*PITCH + 15, G);
    sweep(OY + 2);

    // code 0xA renders blank; its colon stays
    frame_start(16'h1A38);
    probe(OX + PITCH + 15, K); probe(OX + 2*PITCH + 15, G);
    sweep(OY + 2);
    probe(OX + PITCH + 15, K); probe(OX + PITCH + 2, K); probe(OX + PITCH + 36, K);
    sweep(OY + 40);
    probe(OX + PITCH + 54, G);
    sweep(OY + 20);

    // blink with time_out held
    time_out = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame_start(16'h1238);
      probe(OX + 3*PITCH + 15, m_phase ? R : G);
      sweep(OY + 2);
    end
    for (int f = 0; f < 3 && !m_phase; f++) frame_start(16'h1238);
    if (!m_phase) frame_start(16'h1238);
    drop_x = OX + 3*PITCH + 20;
    probe(OX + 3*PITCH + 18, R); probe(OX + 3*PITCH + 20, G); probe(OX + 3*PITCH + 30, G);
    sweep(OY + 2);
    drop_x = -1;
    time_out = 1'b0;

`ifdef VGA_DIGIT_LZB_EN
    frame_start(16'h0005);
    probe(OX + 15, K); probe(OX + PITCH + 15, K); probe(OX + 2*PITCH + 15, K);
    probe(OX + 3*PITCH + 15, G);
    sweep(OY + 2);
    probe(OX + PITCH + 54, K);
    sweep(OY + 20);
    frame_start(16'h0000);
    probe(OX + 15, K); probe(OX + 2*PITCH + 15, K); probe(OX + 3*PITCH + 15, G);
    sweep(OY + 2);
`else
    frame_start(16'h0005);
    probe(OX + 15, G); probe(OX + 2*PITCH + 15, G); probe(OX + 3*PITCH + 15, G);
    sweep(OY + 2);
    probe(OX + PITCH + 54, G);
    sweep(OY + 20);
`endif

    repeat (6) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected pixels never checked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
